// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search message checker.
package rc4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } chk_state_e;

    localparam logic [7:0] CHAR_A     = 8'h61;
    localparam logic [7:0] CHAR_Z     = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    localparam int MSG_LEN_DEF = 32;

endpackage

// File: rtl/msg_checker_if.sv
// Control handshake and decrypted-RAM read port of the message checker.
interface msg_checker_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              finish;
    logic              valid;
    logic [ADDR_W-1:0] fail_index;
    logic [7:0]        bad_char;
    logic [ADDR_W-1:0] address;
    logic [7:0]        q_data;

    modport slave (
        input  start,
        input  q_data,
        output busy,
        output finish,
        output valid,
        output fail_index,
        output bad_char,
        output address
    );

    modport master (
        output start,
        output q_data,
        input  busy,
        input  finish,
        input  valid,
        input  fail_index,
        input  bad_char,
        input  address
    );
endinterface

// File: rtl/char_legal.sv
// Plaintext legality test: lowercase letter or space.
import rc4_pkg::*;

module char_legal (
    input  logic [7:0] ch,
    output logic       legal
);
    assign legal = (ch == CHAR_SPACE)
                 | ((ch >= CHAR_A) & (ch <= CHAR_Z));
endmodule

// File: rtl/msg_checker.sv
// Scans the decrypted RAM and reports the first illegal byte, if any.
import rc4_pkg::*;

module msg_checker #(
    parameter int MSG_LEN      = MSG_LEN_DEF,
    parameter int ADDR_W       = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    msg_checker_if.slave  bus
);
    localparam int WW =
        (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_W:0] LAST =
        (ADDR_W+1)'(MSG_LEN - 1);

    chk_state_e      state;
    logic [ADDR_W:0] k;
    logic [ADDR_W:0] k_nxt;
    logic [WW-1:0]   wcnt;
    logic            legal;

    assign k_nxt = k + (ADDR_W+1)'(1);

    char_legal u_legal (
        .ch    (bus.q_data),
        .legal (legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            k              <= '0;
            wcnt           <= '0;
            bus.address    <= '0;
            bus.busy       <= 1'b0;
            bus.finish     <= 1'b0;
            bus.valid      <= 1'b0;
            bus.fail_index <= '0;
            bus.bad_char   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        k           <= '0;
                        bus.address <= '0;
                        bus.busy    <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (READ_LATENCY == 1) begin
                        state <= CHECK;
                    end else begin
                        wcnt  <= WW'(READ_LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    wcnt <= wcnt - WW'(1);
                    if (wcnt == WW'(1))
                        state <= CHECK;
                end
                CHECK: begin
                    if (!legal) begin
                        bus.busy       <= 1'b0;
                        bus.finish     <= 1'b1;
                        bus.valid      <= 1'b0;
                        bus.fail_index <= k[ADDR_W-1:0];
                        bus.bad_char   <= bus.q_data;
                        state          <= DONE;
                    end else if (k == LAST) begin
                        bus.busy       <= 1'b0;
                        bus.finish     <= 1'b1;
                        bus.valid      <= 1'b1;
                        bus.fail_index <= '0;
                        bus.bad_char   <= '0;
                        state          <= DONE;
                    end else begin
                        k           <= k_nxt;
                        bus.address <= k_nxt[ADDR_W-1:0];
                        state       <= ISSUE;
                    end
                end
                DONE: begin
                    // Result is held until the requester releases start.
                    if (!bus.start) begin
                        bus.finish     <= 1'b0;
                        bus.valid      <= 1'b0;
                        bus.fail_index <= '0;
                        bus.bad_char   <= '0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msg_checker.sv
// Randomized scoreboard bench for msg_checker at read latencies 1 and 2.
module tb_msg_checker;
    localparam int AW = 5;
    localparam int N  = 32;

    typedef struct {
        logic       v;
        int         idx;
        logic [7:0] bad;
        int         edges;
        int         naddr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    msg_checker_if #(.ADDR_W(AW)) if1 ();
    msg_checker_if #(.ADDR_W(AW)) if2 ();

    msg_checker #(
        .MSG_LEN(N), .ADDR_W(AW), .READ_LATENCY(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    msg_checker #(
        .MSG_LEN(N), .ADDR_W(AW), .READ_LATENCY(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave)
    );

    logic [7:0]    mem1 [N];
    logic [7:0]    mem2 [N];
    logic [AW-1:0] p1, p2a, p2b;

    // RAM models; the latency-2 one returns junk until the address has been stable for 2 edges.
    always @(posedge clk) begin
        p1  <= if1.address;
        p2a <= if2.address;
        p2b <= p2a;
    end
    assign if1.q_data = mem1[p1];
    assign if2.q_data = (p2a == p2b) ? mem2[p2b] : 8'hFF;

    bit            sel = 1'b0;
    logic          m_fin, m_busy, m_valid;
    logic [AW-1:0] m_addr, m_fidx;
    logic [7:0]    m_bad;
    assign m_fin   = sel ? if2.finish     : if1.finish;
    assign m_busy  = sel ? if2.busy       : if1.busy;
    assign m_valid = sel ? if2.valid      : if1.valid;
    assign m_addr  = sel ? if2.address    : if1.address;
    assign m_fidx  = sel ? if2.fail_index : if1.fail_index;
    assign m_bad   = sel ? if2.bad_char   : if1.bad_char;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   t0     = 0;
    exp_t sbq [$];
    logic [AW-1:0] alog [$];
    logic pfin = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: logs issued addresses and checks each completed run.
    always @(negedge clk) begin
        if (!rst_n) begin
            alog.delete();
            pfin = 1'b0;
        end else begin
            if (m_busy && (alog.size() == 0 || alog[$] != m_addr))
                alog.push_back(m_addr);
            if (m_fin && !pfin) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got finish with no run pending");
                end else begin
                    exp_t e;
                    bit   ok;
                    e  = sbq.pop_front();
                    ok = 1'b1;
                    foreach (alog[i])
                        if (int'(alog[i]) != i) ok = 1'b0;
                    chk("valid",      m_valid, e.v);
                    chk("fail_index", m_fidx, e.idx);
                    chk("bad_char",   m_bad, e.bad);
                    chk("done_edge",  cyc - t0, e.edges);
                    chk("addr_cnt",   alog.size(), e.naddr);
                    chk("addr_order", ok, 1);
                end
                alog.delete();
            end
            pfin = m_fin;
        end
    end

    function automatic int first_bad(input bit s);
        logic [7:0] b;
        for (int i = 0; i < N; i++) begin
            b = s ? mem2[i] : mem1[i];
            if (!(b == 8'h20 || (b >= 8'h61 && b <= 8'h7A)))
                return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] rand_legal();
        int x;
        x = $urandom_range(0, 26);
        return (x == 26) ? 8'h20 : 8'h61 + 8'(x);
    endfunction

    task automatic fill_legal(input bit s);
        for (int i = 0; i < N; i++)
            if (s) mem2[i] = rand_legal();
            else   mem1[i] = rand_legal();
    endtask

    task automatic run(input bit s, input int lat, input int hold);
        int   fb;
        int   i;
        exp_t e;
        fb      = first_bad(s);
        e.v     = (fb < 0);
        e.idx   = (fb < 0) ? 0 : fb;
        e.bad   = (fb < 0) ? 8'h00 : (s ? mem2[fb] : mem1[fb]);
        e.naddr = (fb < 0) ? N : fb + 1;
        e.edges = e.naddr * (1 + lat);
        @(negedge clk);
        sel = s;
        sbq.push_back(e);
        t0 = cyc + 1;
        if (s) if2.start = 1'b1;
        else   if1.start = 1'b1;
        i = 0;
        while (!m_fin && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (!m_fin) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout: no finish after %0d cycles", i);
            sbq.delete();
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("hold_finish", m_fin, 1);
            chk("hold_busy",   m_busy, 0);
            chk("hold_addr",   m_addr, e.naddr - 1);
        end
        if1.start = 1'b0;
        if2.start = 1'b0;
        @(negedge clk);
        chk("drop_finish", m_fin, 0);
        chk("drop_valid",  m_valid, 0);
        chk("drop_fidx",   m_fidx, 0);
        chk("drop_bad",    m_bad, 0);
    endtask

    initial begin
        string        msg;
        logic [7:0]   bnd [5];
        int           i;
        if1.start = 1'b0;
        if2.start = 1'b0;
        bnd[0] = 8'h60; bnd[1] = 8'h7B; bnd[2] = 8'h00;
        bnd[3] = 8'h1F; bnd[4] = 8'h21;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_address", if1.address, 0);
        chk("rst_busy",    if1.busy, 0);
        chk("rst_finish",  if1.finish, 0);
        chk("rst_valid",   if1.valid, 0);
        chk("rst_fidx",    if1.fail_index, 0);
        chk("rst_bad",     if1.bad_char, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        msg = "the quick brown fox jumps over a";
        for (int j = 0; j < N; j++) mem1[j] = msg[j];
        run(0, 1, 20);

        for (int j = 0; j < N; j++) mem1[j] = 8'h61;
        mem1[5] = 8'h41;
        run(0, 1, 0);

        fill_legal(0);
        mem1[3] = 8'h61; mem1[17] = 8'h7A; mem1[31] = 8'h20;
        run(0, 1, 0);

        for (int b = 0; b < 5; b++) begin
            fill_legal(0);
            mem1[31] = bnd[b];
            run(0, 1, 0);
        end

        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < N; j++)
                mem1[j] = ($urandom_range(0, 19) == 0)
                        ? 8'($urandom_range(0, 255)) : rand_legal();
            run(0, 1, 0);
        end

        fill_legal(0);
        @(negedge clk);
        sel = 1'b0;
        if1.start = 1'b1;
        i = 0;
        while (if1.address != 5'd10 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("reach_k10", if1.address, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_address", if1.address, 0);
        chk("mid_rst_busy",    if1.busy, 0);
        chk("mid_rst_finish",  if1.finish, 0);
        chk("mid_rst_valid",   if1.valid, 0);
        if1.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(0, 1, 0);

        fill_legal(1);
        run(1, 2, 0);
        mem2[7] = 8'h7B;
        run(1, 2, 0);

        repeat (4) @(negedge clk);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pending_runs: got %0d left expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/msg_checker.md
Name: msg_checker

Overview:
- Reads the decrypted-message RAM after the decrypt engine finishes and checks every byte for legal plaintext: lowercase 'a'..'z' (8'h61..8'h7A) or space (8'h20).
- Sits on the read side of the decrypted RAM. The key-search controller uses its valid/finish result to accept the current secret key or advance to the next one.
- It only reads memory and never writes.

Parameters:
- MSG_LEN, 32, number of message bytes checked, addresses 0..MSG_LEN-1.
- ADDR_W, 5, RAM address width; MSG_LEN <= 2**ADDR_W.
- READ_LATENCY, 1, clock edges from address presented to q_data valid; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level request; a run begins when it is sampled high in IDLE.
- q_data  input  8  decrypted RAM read data.
- address  output  ADDR_W  decrypted RAM read address.
- busy  output  1  high in every state except IDLE and DONE.
- finish  output  1  high while in DONE.
- valid  output  1  in DONE: 1 means all bytes are legal, 0 means a failure was found.
- fail_index  output  ADDR_W  address of the first illegal byte; 0 when valid.
- bad_char  output  8  value of the first illegal byte; 0 when valid.

Behaviour:
- Reset: asynchronous, active-low. State goes to IDLE. All outputs and internal counters (k, wait count) clear to 0.
- Reset mid-run: the run is aborted immediately and no result is kept.
- States:
  - IDLE: if start=1, set k=0 and go to ISSUE.
  - ISSUE: address=k. If READ_LATENCY=1, go to CHECK. Otherwise go to WAIT with wait count = READ_LATENCY-1.
  - WAIT: decrement the wait count; go to CHECK when it reaches 1.
  - CHECK: sample q_data.
    - Legal byte and k==MSG_LEN-1: go to DONE with valid=1, fail_index=0, bad_char=0.
    - Legal byte otherwise: k=k+1, go to ISSUE.
    - Illegal byte: go to DONE with valid=0, fail_index=k, bad_char=q_data. The run stops at the first failure and later bytes are not read.
  - DONE: finish=1, and valid/fail_index/bad_char are held. When start=0, go to IDLE; finish drops and the result outputs clear to 0 on that same edge.
- address is registered. It holds the last issued value outside ISSUE.
- start dropping mid-run is ignored; the run completes. start held high through DONE keeps the block in DONE, so there is no automatic restart.
- k is ADDR_W+1 bits wide so the comparison against MSG_LEN cannot wrap.
- Latency, with edge 0 being the edge that samples start high:
  - Full pass: DONE is entered on edge MSG_LEN*(1+READ_LATENCY), which is 64 at the defaults.
  - Failure at byte k: DONE is entered on edge (k+1)*(1+READ_LATENCY).
- Legality boundaries: 8'h60, 8'h7B, 8'h1F, 8'h21 and 8'h00 are illegal. 8'h61, 8'h7A and 8'h20 are legal.

Decomposition:
- rc4_pkg:
  - checker state enum (IDLE, ISSUE, WAIT, CHECK, DONE).
  - constants CHAR_A=8'h61, CHAR_Z=8'h7A, CHAR_SPACE=8'h20.
  - default MSG_LEN.
- Sub-module char_legal: purely combinational, input 8-bit byte, output 1-bit legal flag. It is reused by the key-search controller for early-abort.

Test Plan:
- All-legal pass: RAM preloaded with "the quick brown fox jumps over a" (32 bytes). Pulse start -> finish=1 after edge 64, valid=1, fail_index=0, bad_char=0, 32 reads at addresses 0..31 in order.
- Early failure: byte 5 = 8'h41 ('A'), all others 'a' -> DONE after edge 12, valid=0, fail_index=5, bad_char=8'h41, and address never exceeds 5.
- Boundary characters:
  - Bytes 8'h61, 8'h7A, 8'h20 in a message pass.
  - Separate runs with 8'h60, 8'h7B or 8'h00 at index 31 -> valid=0, fail_index=31.
- Handshake:
  - start held high through DONE -> finish stays 1 and no new reads occur.
  - Dropping start -> IDLE, finish and results return to 0.
  - Raising start again -> a fresh run from address 0.
- Reset mid-run: assert rst_n=0 while k=10 -> all outputs 0 asynchronously. After release, a new start gives a correct full result.
- Latency parameter: READ_LATENCY=2 with an all-legal RAM -> DONE after edge 96, with each q_data sampled exactly 2 edges after its address.
